// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Hits are served from the line array with no wait; misses run writeback/refill over a req/ack port.
module dcache_ctrl #(
  parameter int NUM_LINES = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 32 - 5 - IW;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [31:0]            r_mem_addr;
  logic [LINE_BITS-1:0]   r_mem_wdata;
  logic                   r_fresh;
  logic [IW-1:0]          r_lat_idx;
  logic [TW-1:0]          r_lat_tag;
  logic [NUM_LINES-1:0]   r_valid;
  logic [NUM_LINES-1:0]   r_dirty;
  logic [TW-1:0]          r_tag  [NUM_LINES];
  logic [LINE_BITS-1:0]   r_data [NUM_LINES];

  logic                   w_req_nxt;
  logic                   w_we_nxt;
  logic [31:0]            w_addr_nxt;
  logic [LINE_BITS-1:0]   w_wdata_nxt;
  logic                   w_fresh_nxt;
  logic                   w_latch;
  logic [IW-1:0]          w_idx;
  logic [TW-1:0]          w_tag;
  logic [2:0]             w_word;
  logic                   w_hit;
  logic                   w_ack;
  logic                   w_install;
  logic                   w_wr_hit;
  logic                   w_unused_addr;

  assign w_idx         = cpu_addr_i[4+IW:5];
  assign w_tag         = cpu_addr_i[31:5+IW];
  assign w_word        = cpu_addr_i[4:2];
  assign w_unused_addr = ^cpu_addr_i[1:0];
  assign w_hit         = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  // An ack arriving in the first cycle a request is visible belongs to no transaction.
  assign w_ack         = mem_ack_i & ~r_fresh;
  assign w_install     = (r_state == S_REFILL) & w_ack;
  assign w_wr_hit      = (r_state == S_IDLE) & cpu_req_i & cpu_we_i & w_hit;

  assign cpu_rdata_o = r_data[w_idx][{w_word, 5'd0} +: 32];
  assign cpu_stall_o = rst_i & cpu_req_i & ((r_state != S_IDLE) | ~w_hit);
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

  // Next-state and next memory-port values; request stays up across WB -> REFILL.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_mem_req;
    w_we_nxt    = r_mem_we;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_fresh_nxt = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req_i & ~w_hit) begin
          w_latch     = 1'b1;
          w_fresh_nxt = 1'b1;
          w_req_nxt   = 1'b1;
          if (r_valid[w_idx] & r_dirty[w_idx]) begin
            w_state_nxt = S_WB;
            w_we_nxt    = 1'b1;
            w_addr_nxt  = {r_tag[w_idx], w_idx, 5'd0};
            w_wdata_nxt = r_data[w_idx];
          end else begin
            w_state_nxt = S_REFILL;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = {w_tag, w_idx, 5'd0};
          end
        end else begin
          w_req_nxt = 1'b0;
          w_we_nxt  = 1'b0;
        end
      end
      S_WB: begin
        if (w_ack) begin
          w_state_nxt = S_REFILL;
          w_fresh_nxt = 1'b1;
          w_we_nxt    = 1'b0;
          w_addr_nxt  = {r_lat_tag, r_lat_idx, 5'd0};
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_REFILL: begin
        if (w_ack) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_REFILL;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  // State register, memory-port registers and miss index/tag capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= {LINE_BITS{1'b0}};
      r_fresh     <= 1'b0;
      r_lat_idx   <= {IW{1'b0}};
      r_lat_tag   <= {TW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_fresh     <= w_fresh_nxt;
      if (w_latch) begin
        r_lat_idx <= w_idx;
        r_lat_tag <= w_tag;
      end else begin
        r_lat_idx <= r_lat_idx;
        r_lat_tag <= r_lat_tag;
      end
    end
  end

  // Line status bits: refill installs a clean line, a store hit marks it dirty.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= {NUM_LINES{1'b0}};
      r_dirty <= {NUM_LINES{1'b0}};
    end else if (w_install) begin
      r_valid[r_lat_idx] <= 1'b1;
      r_dirty[r_lat_idx] <= 1'b0;
    end else if (w_wr_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; validity alone guards them.
  always_ff @(posedge clk_i) begin
    if (w_install) begin
      r_data[r_lat_idx] <= mem_rdata_i;
      r_tag[r_lat_idx]  <= r_lat_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][{w_word, 5'd0} +: 32] <= cpu_wdata_i;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected loads and memory transactions are queued
// when stimulus is driven and compared when the cache delivers data or raises a request.
module tb_dcache_ctrl;
  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } mtx_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o, mem_rdata_i;

  int total = 0;
  int bad   = 0;
  int lat   = 10;
  bit stray = 1'b0;
  mtx_t         exp_mem_q[$];
  logic [31:0]  exp_rd_q[$];
  logic [255:0] mem_m [logic [31:0]];

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    logic [31:0] la;
    la = {a[31:5], 5'd0};
    if (la == 32'h0000_0100 && a[4:2] == 3'd0) return 32'h1111_1111;
    return la ^ ({29'd0, a[4:2]} * 32'h0101_0101) ^ 32'h5A00_0000;
  endfunction

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] la);
    if (mem_m.exists(la)) return mem_m[la];
    return init_line(la);
  endfunction

  function automatic mtx_t mk(input logic we, input logic [31:0] a, input logic [255:0] d);
    mtx_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Memory responder: checks each new request against the scoreboard and acks after lat cycles.
  initial begin
    bit           busy;
    int           cnt, cur_lat;
    logic         cur_we;
    logic [31:0]  cur_addr;
    logic [255:0] cur_wd;
    mtx_t         e;
    busy = 1'b0; cnt = 0; cur_lat = 0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (mem_req_o && rst_i) begin
        if (!busy) begin
          busy = 1'b1; cnt = 0; cur_lat = lat;
          cur_we = mem_we_o; cur_addr = mem_addr_o; cur_wd = mem_wdata_o;
          if (exp_mem_q.size() == 0) begin
            chk("mem_unexpected", {223'd0, cur_we, cur_addr}, 256'd0);
          end else begin
            e = exp_mem_q.pop_front();
            chk("mem_we", {255'd0, cur_we}, {255'd0, e.we});
            chk("mem_addr", {224'd0, cur_addr}, {224'd0, e.addr});
            if (e.we) chk("mem_wdata", cur_wd, e.wdata);
          end
        end
        cnt++;
        if (cnt >= cur_lat) begin
          chk("mem_hold", {223'd0, mem_we_o, mem_addr_o}, {223'd0, cur_we, cur_addr});
          if (cur_we) mem_m[cur_addr] = cur_wd;
          else mem_rdata_i = line_of(cur_addr);
          mem_ack_i = 1'b1;
          busy = 1'b0;
        end
      end else begin
        busy = 1'b0;
        if (stray) mem_ack_i = 1'b1;
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_stall, input string tag);
    int n;
    n = 0;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = wd;
    if (!we) exp_rd_q.push_back(exp_rd);
    forever begin
      @(negedge clk_i);
      if (!cpu_stall_o) break;
      n++;
      if (n > 300) begin
        chk({tag, "_timeout"}, 256'(n), 256'd0);
        break;
      end
    end
    if (!we && exp_rd_q.size() > 0) chk({tag, "_rdata"}, {224'd0, cpu_rdata_o}, {224'd0, exp_rd_q.pop_front()});
    chk({tag, "_stall"}, 256'(n), 256'(exp_stall));
    @(posedge clk_i); #2;
    cpu_req_i = 1'b0;
  endtask

  initial begin
    logic [255:0] l;
    int n;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0100; cpu_wdata_i = 32'd0;
    rst_i = 1'b0;
    #12;
    chk("rst_req", {255'd0, mem_req_o}, 256'd0);
    chk("rst_we", {255'd0, mem_we_o}, 256'd0);
    chk("rst_addr", {224'd0, mem_addr_o}, 256'd0);
    chk("rst_stall", {255'd0, cpu_stall_o}, 256'd0);
    cpu_req_i = 1'b0;
    #10 rst_i = 1'b1;
    @(posedge clk_i); #2;

    // 1: cold load miss
    lat = 10;
    exp_mem_q.push_back(mk(1'b0, 32'h0000_0100, 256'd0));
    access(1'b0, 32'h0000_0100, 32'd0, 32'h1111_1111, 11, "t1_load");

    // 2: store hit then load back
    access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, 0, "t2_store");
    access(1'b0, 32'h0000_0104, 32'd0, 32'hDEAD_BEEF, 0, "t2_load");

    // 3: conflicting load forces writeback then refill
    lat = 4;
    l = init_line(32'h0000_0100); l[63:32] = 32'hDEAD_BEEF;
    exp_mem_q.push_back(mk(1'b1, 32'h0000_0100, l));
    exp_mem_q.push_back(mk(1'b0, 32'h0000_0300, 256'd0));
    access(1'b0, 32'h0000_0300, 32'd0, init_word(32'h0000_0300), 9, "t3_load");

    // 4: stray acks while idle, then cold store miss
    stray = 1'b1;
    repeat (3) @(posedge clk_i);
    #2 stray = 1'b0;
    @(negedge clk_i);
    chk("t4_stray_req", {255'd0, mem_req_o}, 256'd0);
    chk("t4_stray_stall", {255'd0, cpu_stall_o}, 256'd0);
    @(posedge clk_i); #2;
    lat = 3;
    exp_mem_q.push_back(mk(1'b0, 32'h0000_0520, 256'd0));
    access(1'b1, 32'h0000_0520, 32'hCAFE_F00D, 32'd0, 4, "t4_store");
    access(1'b0, 32'h0000_0520, 32'd0, 32'hCAFE_F00D, 0, "t4_load");
    l = init_line(32'h0000_0520); l[31:0] = 32'hCAFE_F00D;
    exp_mem_q.push_back(mk(1'b1, 32'h0000_0520, l));
    exp_mem_q.push_back(mk(1'b0, 32'h0000_0720, 256'd0));
    access(1'b0, 32'h0000_0720, 32'd0, init_word(32'h0000_0720), 7, "t4_evict");

    // 5: reset in the middle of a refill
    lat = 20;
    exp_mem_q.push_back(mk(1'b0, 32'h0000_0900, 256'd0));
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0900;
    repeat (5) @(negedge clk_i);
    chk("t5_pre_req", {255'd0, mem_req_o}, 256'd1);
    chk("t5_pre_stall", {255'd0, cpu_stall_o}, 256'd1);
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    #1;
    chk("t5_rst_req", {255'd0, mem_req_o}, 256'd0);
    chk("t5_rst_stall", {255'd0, cpu_stall_o}, 256'd0);
    cpu_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #2;
    lat = 5;
    exp_mem_q.push_back(mk(1'b0, 32'h0000_0100, 256'd0));
    access(1'b0, 32'h0000_0100, 32'd0, 32'h1111_1111, 6, "t5_reload");

    // 6: request withdrawn during refill; line still installed
    lat = 8;
    exp_mem_q.push_back(mk(1'b0, 32'h0000_1240, 256'd0));
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_1248;
    repeat (3) @(posedge clk_i);
    #2 cpu_req_i = 1'b0;
    n = 0;
    while (mem_req_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("t6_req_drop", {255'd0, mem_req_o}, 256'd0);
    @(posedge clk_i); #2;
    access(1'b0, 32'h0000_1248, 32'd0, init_word(32'h0000_1248), 0, "t6_reissue");

    repeat (3) @(posedge clk_i);
    chk("mem_q_left", 256'(exp_mem_q.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
